// File: rtl/bcd_counter_mod10_pkg.sv
// Shared timer constants for the BCD digit chain and the timer controller.
package bcd_counter_mod10_pkg;

  localparam int              BCD_W    = 4;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_DEC  = 2'd2
  } bcd_op_e;

  // Out-of-range presets saturate so the digit register only ever holds BCD.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_counter_mod10.sv
// One BCD down-counting timer digit: load, decrement with 0->9 wrap, borrow out.
module bcd_counter_mod10
  import bcd_counter_mod10_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             loadn,
  input  logic             en,
  input  logic [BCD_W-1:0] data,
  output logic [BCD_W-1:0] out,
  output logic             tc,
  output logic             zero
);

  logic [BCD_W-1:0] out_d, out_q;
  bcd_op_e          op;

  // Load beats count; clr is handled in the register itself.
  always_comb begin
    op = OP_HOLD;
    if (!loadn)  op = OP_LOAD;
    else if (en) op = OP_DEC;
  end

  always_comb begin
    out_d = out_q;
    case (op)
      OP_LOAD: out_d = bcd_clamp(data);
      OP_DEC:  out_d = (out_q == BCD_ZERO) ? BCD_MAX : out_q - 4'd1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) out_q <= BCD_ZERO;
    else     out_q <= out_d;
  end

  // Borrow is ungated by clr/loadn so the digit above decides its own priority.
  assign out  = out_q;
  assign zero = (out_q == BCD_ZERO);
  assign tc   = en & zero;

endmodule

// File: tb/tb_bcd_counter_mod10.sv
// Self-checking bench: directed plan plus random traffic against a digit model.
module tb_bcd_counter_mod10;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       loadn = 1'b1;
  logic       en = 1'b0;
  logic [3:0] data = 4'd0;
  logic [3:0] out;
  logic       tc;
  logic       zero;

  int n_cmp = 0;
  int n_err = 0;

  int model_digit = 0;
  bit model_valid = 1'b0;

  bcd_counter_mod10 dut (
    .clk   (clk),
    .clr   (clr),
    .loadn (loadn),
    .en    (en),
    .data  (data),
    .out   (out),
    .tc    (tc),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  // Reference digit: plain decimal arithmetic on the priority rules.
  always @(posedge clk) begin
    if (clr) begin
      model_digit <= 0;
      model_valid <= 1'b1;
    end else if (!loadn) begin
      model_digit <= (int'(data) > 9) ? 9 : int'(data);
    end else if (en) begin
      model_digit <= (model_digit + 9) % 10;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare on the falling edge, once the model is defined.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_out",  int'(out),  model_digit);
      chk("model_zero", int'(zero), (model_digit == 0) ? 1 : 0);
      chk("model_tc",   int'(tc),   (en && model_digit == 0) ? 1 : 0);
    end
  end

  task automatic drive(input bit c, input bit l, input bit e, input logic [3:0] d);
    clr = c; loadn = l; en = e; data = d;
    @(posedge clk);
    #1;
  endtask

  int exp_seq [7] = '{4, 3, 2, 1, 0, 9, 8};

  initial begin
    // Reset
    repeat (3) drive(1'b1, 1'b1, 1'b0, 4'd0);
    chk("rst_out", int'(out), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_tc", int'(tc), 0);
    en = 1'b1; #1;
    chk("rst_tc_en", int'(tc), 1);
    drive(1'b1, 1'b1, 1'b1, 4'd0);
    chk("rst_en_out", int'(out), 0);

    // Load and count
    drive(1'b0, 1'b0, 1'b0, 4'd4);
    chk("load4", int'(out), 4);
    drive(1'b0, 1'b1, 1'b1, 4'd0);
    chk("dec_3", int'(out), 3);
    chk("dec_3_tc", int'(tc), 0);
    drive(1'b0, 1'b1, 1'b1, 4'd0);
    chk("dec_2", int'(out), 2);
    chk("dec_2_zero", int'(zero), 0);

    // Pause and reset
    repeat (2) drive(1'b0, 1'b1, 1'b0, 4'd0);
    chk("pause", int'(out), 2);
    chk("pause_tc", int'(tc), 0);
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    chk("clr_mid", int'(out), 0);
    chk("clr_mid_zero", int'(zero), 1);

    // Full countdown with wrap
    drive(1'b0, 1'b0, 1'b0, 4'd5);
    chk("load5", int'(out), 5);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'd0);
      chk("wrap_seq", int'(out), exp_seq[i]);
      chk("wrap_tc", int'(tc), (exp_seq[i] == 0) ? 1 : 0);
    end

    // Load zero then count
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    chk("load0", int'(out), 0);
    chk("load0_tc", int'(tc), 0);
    en = 1'b1; loadn = 1'b1; #1;
    chk("load0_tc_en", int'(tc), 1);
    drive(1'b0, 1'b1, 1'b1, 4'd0);
    chk("load0_wrap", int'(out), 9);
    chk("load0_wrap_tc", int'(tc), 0);

    // Priority and clamp
    drive(1'b0, 1'b0, 1'b1, 4'd7);
    chk("load_beats_en", int'(out), 7);
    drive(1'b1, 1'b0, 1'b1, 4'd3);
    chk("clr_beats_load", int'(out), 0);
    drive(1'b0, 1'b0, 1'b0, 4'd12);
    chk("clamp12", int'(out), 9);
    drive(1'b0, 1'b0, 1'b0, 4'd15);
    chk("clamp15", int'(out), 9);
    drive(1'b0, 1'b0, 1'b0, 4'd10);
    chk("clamp10", int'(out), 9);

    // Random traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 29) == 0),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
